hilo_mdu: RTL and testbench

Parametrised HI/LO register unit with an integrated multiply/divide engine for the MIPS execute stage. Holds the architectural HI and LO registers, accepts direct MTHI/MTLO writes, and performs single-cycle multiplies and a multi-cycle iterative divide. A start/busy/done handshake lets the pipeline stall on divides, and a cancel input lets exceptions flush an in-flight divide without touching HI/LO.

---
 rtl/hilo_mdu.sv | 159 +++++++++++++++
 tb/tb_hilo_mdu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// MIPS HI/LO register unit with single-cycle multiply and iterative restoring divide.
// Define HILO_MADD_EN to build MADD/MSUB (ops 5/6); otherwise they decode as NOP.
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO      = '0;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
`ifdef HILO_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
`endif

  typedef enum logic {IDLE, CALC} state_t;
  state_t state, next_state;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dvd, dvs, rem, a_save;
  logic               neg_q, neg_r, div_zero;

  logic               is_mul, is_div, is_acc;
  logic               accept, mul_accept, div_accept, div_last, div_finish;
  logic [2*WIDTH-1:0] prod_s, prod_u, mul_result;
  logic               div_signed, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     rem_sh, diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next, dvd_next, q_fin, r_fin;

  assign busy = (state == CALC);

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef HILO_MADD_EN
    is_acc = (op == OP_MADD) || (op == OP_MSUB);
`else
    is_acc = 1'b0;
`endif
    accept     = start && !busy && !cancel && (is_mul || is_div || is_acc);
    mul_accept = accept && (is_mul || is_acc);
    div_accept = accept && is_div;
  end

  // Low 2W bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

  always_comb begin
    mul_result = prod_s;
    case (op)
      OP_MULTU: mul_result = prod_u;
`ifdef HILO_MADD_EN
      OP_MADD:  mul_result = {hi_o, lo_o} + prod_s;
      OP_MSUB:  mul_result = {hi_o, lo_o} - prod_s;
`endif
      default:  mul_result = prod_s;
    endcase
  end

  always_comb begin
    div_signed = (op == OP_DIV);
    sa         = div_signed & src_a[WIDTH-1];
    sb         = div_signed & src_b[WIDTH-1];
    mag_a      = sa ? (ZERO - src_a) : src_a;
    mag_b      = sb ? (ZERO - src_b) : src_b;
  end

  // One restoring step: quotient bits shift into dvd as dividend bits shift out.
  always_comb begin
    rem_sh   = {rem, dvd[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvs};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], q_bit};
    q_fin    = div_zero ? '1 : (neg_q ? (ZERO - dvd_next) : dvd_next);
    r_fin    = div_zero ? a_save : (neg_r ? (ZERO - rem_next) : rem_next);
  end

  assign div_last   = busy && (cnt == LAST_ITER);
  assign div_finish = div_last && !cancel;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (div_accept) next_state = CALC;
      CALC: if (cancel || div_last) next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      a_save   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (div_accept) begin
      cnt      <= '0;
      dvd      <= mag_a;
      dvs      <= mag_b;
      rem      <= '0;
      a_save   <= src_a;
      neg_q    <= sa ^ sb;
      neg_r    <= sa;
      div_zero <= (src_b == ZERO);
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      dvd <= dvd_next;
      rem <= rem_next;
    end
  end

  // Multiply/divide results are assigned last so they override same-edge direct writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
      done <= 1'b0;
    end else begin
      if (hi_we) hi_o <= hi_i;
      if (lo_we) lo_o <= lo_i;
      if (mul_accept) {hi_o, lo_o} <= mul_result;
      if (div_finish) {hi_o, lo_o} <= {r_fin, q_fin};
      done <= mul_accept || div_finish;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: stimulus pushes expected {HI,LO}, a monitor checks on each done pulse.
// Expectations for ops 5/6 follow whether HILO_MADD_EN is defined.
module tb_hilo_mdu;

  localparam int WIDTH = 32;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;

  logic             clk = 1'b0;
  logic             rst, hi_we, lo_we, start, cancel, busy, done;
  logic [WIDTH-1:0] hi_i, lo_i, src_a, src_b, hi_o, lo_o;
  logic [2:0]       op;

  int tests  = 0;
  int failed = 0;
  logic [2*WIDTH-1:0] sb_q[$];

  hilo_mdu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .hi_we(hi_we), .lo_we(lo_we), .hi_i(hi_i), .lo_i(lo_i),
    .start(start), .op(op), .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit expect_done, input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el);
    if (expect_done) sb_q.push_back({eh, el});
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic waitIdle(input string name, input int expected);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (busy === 1'b1) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s_timeout: busy still %b after %0d cycles, expected 0", name, busy, n);
    end else if (expected > 0) begin
      checkOutput(name, n, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    logic [2*WIDTH-1:0] exp_v;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_done: done=1 hi=%h lo=%h, expected no pulse", hi_o, lo_o);
      end else begin
        exp_v = sb_q.pop_front();
        checkOutput("result_hi", hi_o, exp_v[2*WIDTH-1:WIDTH]);
        checkOutput("result_lo", lo_o, exp_v[WIDTH-1:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; hi_we = 1'b0; lo_we = 1'b0; start = 1'b0; cancel = 1'b0;
    hi_i = '0; lo_i = '0; src_a = '0; src_b = '0; op = 3'd0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_hi", hi_o, 32'h0);
    checkOutput("reset_lo", lo_o, 32'h0);
    checkOutput("reset_busy", busy, 32'h0);
    checkOutput("reset_done", done, 32'h0);

    hi_we = 1'b1; hi_i = 32'h1234_5678;
    lo_we = 1'b1; lo_i = 32'h9ABC_DEF0;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    checkOutput("mthi", hi_o, 32'h1234_5678);
    checkOutput("mtlo", lo_o, 32'h9ABC_DEF0);
    rst = 1'b1;
    tick();
    checkOutput("rst_hi", hi_o, 32'h0);
    checkOutput("rst_lo", lo_o, 32'h0);
    rst = 1'b0;

    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    checkOutput("mult_busy", busy, 32'h0);
    applyStimulus(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);
    tick();

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    checkOutput("div_busy", busy, 32'h1);
    waitIdle("div_latency", 32);
    tick();
    applyStimulus(OP_DIVU, 32'd7, 32'd0, 1'b1, 32'd7, 32'hFFFF_FFFF);
    waitIdle("divz_latency", 32);
    tick();
    applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD);
    waitIdle("divneg_latency", 32);
    tick();

    // Cancel partway through: HI/LO keep 1 / -3 and no done pulse.
    applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checkOutput("cancel_busy", busy, 32'h0);
    checkOutput("cancel_done", done, 32'h0);
    tick(); tick();
    checkOutput("cancel_hi", hi_o, 32'd1);
    checkOutput("cancel_lo", lo_o, 32'hFFFF_FFFD);

    applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    tick(); tick(); tick();
    applyStimulus(OP_MULT, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0);
    checkOutput("ignored_start_busy", busy, 32'h1);
    waitIdle("busy_start_latency", 28);
    tick();
    checkOutput("ignored_start_hi", hi_o, 32'd2);
    checkOutput("ignored_start_lo", lo_o, 32'd14);

    // MTLO mid-divide, then MTHI on the completion edge.
    applyStimulus(OP_DIVU, 32'd100, 32'd9, 1'b1, 32'd1, 32'd11);
    tick(); tick(); tick();
    lo_we = 1'b1; lo_i = 32'h55;
    tick();
    lo_we = 1'b0;
    checkOutput("mid_mtlo", lo_o, 32'h55);
    for (int i = 0; i < 27; i++) tick();
    checkOutput("mid_mtlo_hold", lo_o, 32'h55);
    checkOutput("mid_busy", busy, 32'h1);
    hi_we = 1'b1; hi_i = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0;
    checkOutput("complete_busy", busy, 32'h0);
    tick();
    checkOutput("complete_hi", hi_o, 32'd1);

    // MIN / -1, then a multiply accepted in the done cycle.
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000);
    waitIdle("minneg_latency", 32);
    applyStimulus(OP_MULT, 32'd7, 32'd6, 1'b1, 32'h0, 32'd42);
    checkOutput("b2b_lo", lo_o, 32'd42);
    tick();

    applyStimulus(OP_DIV, 32'd50, 32'd3, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_div_busy", busy, 32'h0);
    checkOutput("rst_div_hi", hi_o, 32'h0);
    checkOutput("rst_div_lo", lo_o, 32'h0);
    for (int i = 0; i < 35; i++) tick();
    checkOutput("rst_div_lo_later", lo_o, 32'h0);

    lo_we = 1'b1; lo_i = 32'd5;
    tick();
    lo_we = 1'b0;
`ifdef HILO_MADD_EN
    applyStimulus(OP_MADD, 32'd2, 32'd3, 1'b1, 32'h0, 32'd11);
    applyStimulus(OP_MSUB, 32'd4, 32'd4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    tick();
`else
    applyStimulus(OP_MADD, 32'd2, 32'd3, 1'b0, 32'h0, 32'h0);
    checkOutput("madd_off_done", done, 32'h0);
    applyStimulus(OP_MSUB, 32'd4, 32'd4, 1'b0, 32'h0, 32'h0);
    checkOutput("msub_off_done", done, 32'h0);
    checkOutput("madd_off_busy", busy, 32'h0);
    checkOutput("madd_off_hi", hi_o, 32'h0);
    checkOutput("madd_off_lo", lo_o, 32'd5);
`endif
    tick(); tick();

    tests++;
    if (sb_q.size() != 0) begin
      failed++;
      $display("[TB] FAIL scoreboard_drain: %0d results pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
